// File: rtl/fp8_pkg.sv
// Shared FP8 minifloat constants and the dot-product FSM encoding.
// FP8 layout: [7] sign, [6:4] exponent (bias 3), [3:0] fraction with hidden 1.
package fp8_pkg;

  localparam int FP8_EXP_BIAS = 3;
  localparam int FP8_EXP_W    = 3;
  localparam int FP8_FRAC_W   = 4;
  localparam int FP8_FIX_FRAC = 7;
  localparam int FP8_FIX_INT  = 5;
  localparam int FP8_MAG_W    = FP8_FIX_INT + FP8_FIX_FRAC;

  localparam logic [7:0] FP8_ZERO = 8'h00;
  localparam logic [7:0] FP8_MAX  = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_NORM  = 2'd2,
    ST_OUT   = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fp8_normalize.sv
// Converts a signed fixed-point sum (7 fraction bits) into one FP8 value:
// leading-one detection, truncated fraction, underflow to zero, saturation.
module fp8_normalize
  import fp8_pkg::*;
#(
  parameter int ACC_W = 17
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic        [7:0]       o_fp8
);

  localparam int LW = $clog2(ACC_W);
  // Leading-one bit positions that map to exponent 0 and exponent 7.
  localparam int UF_LEAD = FP8_FIX_FRAC - FP8_EXP_BIAS;
  localparam int OF_LEAD = UF_LEAD + (1 << FP8_EXP_W) - 1;

  logic [ACC_W-1:0]      w_mag;
  logic [LW-1:0]         w_lead;
  logic                  w_sign;
  logic                  w_nz;
  logic [FP8_EXP_W-1:0]  w_exp;
  logic [FP8_FRAC_W-1:0] w_frac;

  always_comb begin
    w_sign = i_acc[ACC_W-1];
    if (w_sign) begin
      w_mag = ACC_W'(-i_acc);
    end else begin
      w_mag = ACC_W'(i_acc);
    end
  end

  // Highest set bit wins, so scan upward and keep overwriting.
  always_comb begin
    w_lead = '0;
    for (int i = 0; i < ACC_W; i++) begin
      w_lead = w_mag[i] ? LW'(i) : w_lead;
    end
    w_nz = |w_mag;
  end

  always_comb begin
    w_exp  = FP8_EXP_W'(w_lead - LW'(UF_LEAD));
    w_frac = FP8_FRAC_W'(w_mag >> (w_lead - LW'(UF_LEAD)));
    if (!w_nz || (w_lead < LW'(UF_LEAD))) begin
      o_fp8 = FP8_ZERO;
    end else if (w_lead > LW'(OF_LEAD)) begin
      o_fp8 = FP8_MAX | {w_sign, 7'd0};
    end else begin
      o_fp8 = {w_sign, w_exp, w_frac};
    end
  end

endmodule

// File: rtl/fp8_dot_accumulator.sv
// Sums a stream of FP8 products exactly in signed fixed point and emits the
// dot product as one FP8 value with a valid/ready handshake on each side.
module fp8_dot_accumulator
  import fp8_pkg::*;
#(
  parameter int MAX_TERMS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int CNT_W = $clog2(MAX_TERMS);
  localparam int ACC_W = 13 + CNT_W;

  fsm_state_t               r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_count;
  logic [7:0]               r_out_data;
  logic                     r_out_valid;
  logic                     r_in_ready;

  logic [FP8_MAG_W-1:0]     w_term_mag;
  logic signed [ACC_W-1:0]  w_term_ext;
  logic signed [ACC_W-1:0]  w_term;
  logic [7:0]               w_norm;
  logic                     w_accept;

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign w_accept  = in_valid & r_in_ready;

  // {1,ffff} shifted by the raw exponent lands with 7 fraction bits.
  always_comb begin
    w_term_mag = FP8_MAG_W'({1'b1, in_data[3:0]}) << in_data[6:4];
    w_term_ext = $signed({{(ACC_W - FP8_MAG_W){1'b0}}, w_term_mag});
    if (in_data[6:0] == 7'd0) begin
      w_term = '0;
    end else if (in_data[7]) begin
      w_term = -w_term_ext;
    end else begin
      w_term = w_term_ext;
    end
  end

  fp8_normalize #(
    .ACC_W (ACC_W)
  ) u_normalize (
    .i_acc (r_acc),
    .o_fp8 (w_norm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_data  <= FP8_ZERO;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc   <= w_term;
            r_count <= CNT_W'(1);
            if (in_last) begin
              r_state    <= ST_NORM;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc   <= r_acc + w_term;
            r_count <= r_count + CNT_W'(1);
            // The MAX_TERMS-th term closes the product even without in_last.
            if (in_last || (r_count == CNT_W'(MAX_TERMS - 1))) begin
              r_state    <= ST_NORM;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_NORM: begin
          r_out_data  <= w_norm;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_acc       <= '0;
          r_count     <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_dot_accumulator.sv
// Directed, table-driven bench for fp8_dot_accumulator: two-term products from
// a vector table plus hand sequences for forced close, back-pressure and reset.
module tb_fp8_dot_accumulator;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int checks;
  int failures;

  logic [7:0] terms [16];
  vec_t       vecs  [15];

  fp8_dot_accumulator #(
    .MAX_TERMS (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", nm, act, expv);
    end
  endtask

  // Entered and left at a negedge; inputs change and outputs are sampled there.
  task automatic run_dot(input int n, input bit use_last, input logic [7:0] expv,
                         input int hold, input string nm);
    int waitc;
    for (int i = 0; i < n; i++) begin
      in_data  = terms[i];
      in_valid = 1'b1;
      in_last  = use_last && (i == n - 1);
      waitc = 0;
      while (!in_ready && waitc < 50) begin
        @(negedge clk);
        waitc++;
      end
      if (!in_ready) begin
        chk({nm, " in_ready timeout"}, {7'd0, in_ready}, 8'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({nm, " T+1 out_valid"}, {7'd0, out_valid}, 8'd0);
    chk({nm, " T+1 in_ready"}, {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    chk({nm, " T+2 out_valid"}, {7'd0, out_valid}, 8'd1);
    chk({nm, " T+2 in_ready"}, {7'd0, in_ready}, 8'd0);
    chk({nm, " out_data"}, out_data, expv);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " hold out_valid"}, {7'd0, out_valid}, 8'd1);
      chk({nm, " hold out_data"}, out_data, expv);
      chk({nm, " hold in_ready"}, {7'd0, in_ready}, 8'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " after out_valid"}, {7'd0, out_valid}, 8'd0);
    chk({nm, " after in_ready"}, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    vecs = '{
      '{8'h30, 8'h30, 8'h40},  // 1+1 = 2.0
      '{8'h38, 8'h38, 8'h48},  // 1.5+1.5 = 3.0
      '{8'h30, 8'hB0, 8'h00},  // cancels to exact zero
      '{8'h31, 8'hB0, 8'h00},  // 0.0625 underflows
      '{8'hB0, 8'hB0, 8'hC0},  // -2.0
      '{8'h00, 8'h30, 8'h30},  // zero term
      '{8'h80, 8'h80, 8'h00},  // negative zero inputs give +0
      '{8'h60, 8'h60, 8'h70},  // 16.0, largest exponent
      '{8'h70, 8'h70, 8'h7F},  // 32.0 saturates
      '{8'hF0, 8'hF0, 8'hFF},  // -32.0 saturates negative
      '{8'h00, 8'h01, 8'h01},  // 0.1328, smallest exponent
      '{8'h30, 8'h8F, 8'h28},  // 97/128 truncates to 0.75
      '{8'h8F, 8'h80, 8'h8F},  // negative small value
      '{8'h0F, 8'h00, 8'h0F},  // 31/128
      '{8'hB0, 8'h0F, 8'hA8}   // -97/128 truncates toward zero
    };

    @(negedge clk);
    @(negedge clk);
    chk("reset in_ready", {7'd0, in_ready}, 8'd0);
    chk("reset out_valid", {7'd0, out_valid}, 8'd0);
    chk("reset out_data", out_data, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", {7'd0, in_ready}, 8'd1);

    for (int v = 0; v < 15; v++) begin
      terms[0] = vecs[v].a;
      terms[1] = vecs[v].b;
      run_dot(2, 1'b1, vecs[v].exp, 0, $sformatf("vec%0d", v));
    end

    // Single-term product closes from IDLE.
    terms[0] = 8'h38;
    run_dot(1, 1'b1, 8'h38, 0, "single");

    // Three terms: 1+1+1 = 3.0.
    for (int i = 0; i < 3; i++) terms[i] = 8'h30;
    run_dot(3, 1'b1, 8'h48, 0, "three");

    // Forced close after 16 terms with no in_last: 16*31 = 496 saturates.
    for (int i = 0; i < 16; i++) terms[i] = 8'h7F;
    run_dot(16, 1'b0, 8'h7F, 0, "force_pos");
    for (int i = 0; i < 16; i++) terms[i] = 8'hFF;
    run_dot(16, 1'b0, 8'hFF, 0, "force_neg");

    // Output held under back-pressure for 5 cycles.
    terms[0] = 8'h38;
    terms[1] = 8'h38;
    run_dot(2, 1'b1, 8'h48, 5, "hold");

    // Reset in the middle of accumulation discards the partial sum.
    in_data  = 8'h30;
    in_valid = 1'b1;
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset in_ready", {7'd0, in_ready}, 8'd0);
    chk("midreset out_valid", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    terms[0] = 8'h30;
    run_dot(1, 1'b1, 8'h30, 0, "after_reset");

    // Reset while a result is pending drops out_valid.
    terms[0] = 8'h30;
    terms[1] = 8'h30;
    in_data  = 8'h30;
    in_valid = 1'b1;
    in_last  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pending out_valid", {7'd0, out_valid}, 8'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("outreset out_valid", {7'd0, out_valid}, 8'd0);
    chk("outreset out_data", out_data, 8'h00);
    @(negedge clk);
    run_dot(2, 1'b1, 8'h40, 0, "after_outreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
